upsp_axis_out_packer: RTL and testbench
=======================================

Name: upsp_axis_out_packer

Overview:
- Downstream stage of the access-control output stream. Consumes one 24-bit RGB pixel per beat from the access-control master AXI-Stream.
- Packs pixels into 32-bit words for the DMA write channel (four pixels become three words). Marks end of frame with tlast and a flush word carrying a partial tkeep.
- Tracks line and pixel position; flags line-length errors. Sits between the access-control block's output port and the final-out AXI-Stream.

Parameters:
- DST_IMG_WIDTH, 4096, output pixels per line (>=1).
- DST_IMG_HEIGHT, 2160, output lines per frame (>=1).
- COL_W, $clog2(DST_IMG_WIDTH)+1, column counter width (derived).
- ROW_W, $clog2(DST_IMG_HEIGHT)+1, row counter width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- soft_rst  in  1  synchronous clear, same effect as reset, for one-cycle pulse from access control.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  24  pixel; byte0=[7:0], byte1=[15:8], byte2=[23:16].
- s_axis_tlast  in  1  end-of-line marker from upstream.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  32  packed word; stream byte 4n+k in [8k+7:8k].
- m_axis_tkeep  out  4  valid byte lanes.
- m_axis_tlast  out  1  last word of frame.
- frame_done  out  1  one-cycle pulse on tlast handshake.
- line_err  out  1  sticky, s_axis_tlast disagreed with column counter.

Behaviour:
- Reset (async or soft_rst): all outputs 0, residual count 0, col=row=0, state RUN, line_err cleared.
- Residual accumulator: holds cnt bytes, cnt in 0..3 between pixels.
- Output register: single beat. Held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Output register is free when !m_axis_tvalid || m_axis_tready.
- State RUN:
  - s_axis_tready = output register free.
  - On input handshake: cnt' = cnt+3.
  - If cnt' >= 4: load output with low 4 bytes (tkeep=4'hF) and set cnt = cnt'-4. Otherwise just store, with no output beat.
  - Latency from input handshake to m_axis_tvalid is 1 cycle when a word forms.
  - m_axis_tvalid drops after handshake if no new word is loaded that cycle.
- Position counters:
  - col increments per accepted pixel.
  - At col == DST_IMG_WIDTH-1: col=0, row++.
  - At last pixel of frame (row == H-1, col == W-1), go to end-of-frame handling.
- line_err: set if s_axis_tlast=1 on a non-final column, or 0 on the final column. It does not stall the datapath.
- End of frame, on the last pixel:
  - If cnt' == 4: emit the word with tlast=1 and return to RUN with counters zeroed.
  - If cnt' < 4 (values 3): emit the residual word with tkeep=(1<<cnt')-1, upper bytes 0, tlast=1.
  - If cnt' > 4 (5 or 6): emit a full word with tlast=0, then enter FLUSH.
- State FLUSH:
  - s_axis_tready=0.
  - When the output register is free, emit the residual (cnt 1 or 2 bytes) with tkeep 4'h1 or 4'h3, upper bytes 0, tlast=1.
  - Then return to RUN with cnt=0 and col=row=0.
- frame_done: pulses the cycle m_axis_tvalid && m_axis_tready && m_axis_tlast.
- Simultaneous output handshake and new word load: allowed, giving back-to-back throughput of 1 word/cycle.
- Reset mid-frame: residual is discarded with no flush beat, and the next frame starts at col=row=0.

Optional Feature:
- Macro: UPSP_OUT_PACKER_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt (out, 32): counts cycles with m_axis_tvalid=1 && m_axis_tready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset, soft_rst, and on each frame_done.
- When undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- W=4,H=1, m_axis_tready=1: pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A with tlast on the fourth.
  - Expect words 0x04030201, 0x08070605, 0x0C0B0A09, all with tkeep F.
  - tlast on the third word; frame_done 1 pulse; line_err=0.
- W=2,H=1: pixels 0x030201, 0x060504.
  - Expect 0x04030201 (keep F, tlast 0), then FLUSH word 0x00000605 (keep 3, tlast 1).
  - s_axis_tready=0 during FLUSH.
- W=1,H=1: pixel 0xAABBCC -> single word 0x00AABBCC, keep 7, tlast 1.
- W=4,H=2 with m_axis_tready toggling 1/0 every cycle:
  - 6 words, data held stable during stalls, no drop or duplicate.
  - tlast only on word 6.
  - With macro on: stall_cnt equals the number of stalled cycles before frame_done.
- W=4,H=1 with s_axis_tlast asserted on the second pixel: line_err=1 and sticky; output data unchanged. soft_rst clears it.
- Assert rst_n low after 3 pixels of a W=4 frame, then send a fresh 4-pixel frame:
  - No residual from before reset is emitted.
  - Output matches the first scenario exactly.

Source files
------------

// File: rtl/upsp_axis_out_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI-Stream words (4 pixels -> 3 words) with frame tlast/flush.
// Optional stall counter port enabled by defining UPSP_OUT_PACKER_STALL_CNT_EN.
`timescale 1ns/1ps
module upsp_axis_out_packer #(
  parameter int DST_IMG_WIDTH  = 4096,
  parameter int DST_IMG_HEIGHT = 2160,
  parameter int COL_W          = $clog2(DST_IMG_WIDTH) + 1,
  parameter int ROW_W          = $clog2(DST_IMG_HEIGHT) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        soft_rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
`ifdef UPSP_OUT_PACKER_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        frame_done,
  output logic        line_err
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [23:0]      resid;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic        out_free;
  logic        accept;
  logic        last_col;
  logic        last_px;
  logic [2:0]  cnt_next;
  logic [47:0] merged;
  logic [3:0]  flush_keep;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == RUN) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_col      = (col == COL_W'(DST_IMG_WIDTH - 1));
  assign last_px       = last_col && (row == ROW_W'(DST_IMG_HEIGHT - 1));
  assign frame_done    = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Residual bytes sit at the bottom; the new pixel is appended just above them.
  always_comb begin
    cnt_next   = {1'b0, cnt} + 3'd3;
    merged     = {24'b0, resid} | ({24'b0, s_axis_tdata} << {cnt, 3'b000});
    flush_keep = (cnt == 2'd2) ? 4'h3 : 4'h1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      cnt           <= '0;
      resid         <= '0;
      col           <= '0;
      row           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      line_err      <= 1'b0;
    end else if (soft_rst) begin
      state         <= RUN;
      cnt           <= '0;
      resid         <= '0;
      col           <= '0;
      row           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      line_err      <= 1'b0;
    end else begin
      if (out_free) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      case (state)
        RUN: begin
          if (accept) begin
            if (s_axis_tlast != last_col) line_err <= 1'b1;
            if (last_col) begin
              col <= '0;
              row <= last_px ? '0 : row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (last_px) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= merged[31:0];
              if (cnt_next > 3'd4) begin
                // Six or five bytes: full word now, remainder goes out as a separate flush beat.
                m_axis_tkeep <= 4'hF;
                m_axis_tlast <= 1'b0;
                resid        <= {8'b0, merged[47:32]};
                cnt          <= cnt_next[1:0];
                state        <= FLUSH;
              end else begin
                m_axis_tkeep <= (cnt_next == 3'd4) ? 4'hF : 4'h7;
                m_axis_tlast <= 1'b1;
                resid        <= '0;
                cnt          <= '0;
              end
            end else if (cnt_next >= 3'd4) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= merged[31:0];
              m_axis_tkeep  <= 4'hF;
              m_axis_tlast  <= 1'b0;
              resid         <= {8'b0, merged[47:32]};
              cnt           <= cnt_next[1:0];
            end else begin
              resid <= merged[23:0];
              cnt   <= cnt_next[1:0];
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {8'b0, resid};
            m_axis_tkeep  <= flush_keep;
            m_axis_tlast  <= 1'b1;
            resid         <= '0;
            cnt           <= '0;
            state         <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef UPSP_OUT_PACKER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (soft_rst || frame_done) begin
      stall_cnt <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_upsp_axis_out_packer.sv
// Directed bench for upsp_axis_out_packer: four instances with different frame geometries.
`timescale 1ns/1ps
module tb_upsp_axis_out_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [4];
  logic        soft_rst [4];
  logic        s_valid [4];
  logic        s_ready [4];
  logic [23:0] s_data [4];
  logic        s_last [4];
  logic        m_valid [4];
  logic        m_ready [4];
  logic [31:0] m_data [4];
  logic [3:0]  m_keep [4];
  logic        m_last [4];
  logic        frame_done [4];
  logic        line_err [4];
`ifdef UPSP_OUT_PACKER_STALL_CNT_EN
  logic [31:0] stall_cnt [4];
`endif

  // Instance geometry: 0 -> 4x1, 1 -> 2x1, 2 -> 1x1, 3 -> 4x2
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int W = (gi == 1) ? 2 : ((gi == 2) ? 1 : 4);
    localparam int H = (gi == 3) ? 2 : 1;
    upsp_axis_out_packer #(.DST_IMG_WIDTH(W), .DST_IMG_HEIGHT(H)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[gi]),
      .soft_rst      (soft_rst[gi]),
      .s_axis_tvalid (s_valid[gi]),
      .s_axis_tready (s_ready[gi]),
      .s_axis_tdata  (s_data[gi]),
      .s_axis_tlast  (s_last[gi]),
      .m_axis_tvalid (m_valid[gi]),
      .m_axis_tready (m_ready[gi]),
      .m_axis_tdata  (m_data[gi]),
      .m_axis_tkeep  (m_keep[gi]),
      .m_axis_tlast  (m_last[gi]),
`ifdef UPSP_OUT_PACKER_STALL_CNT_EN
      .stall_cnt     (stall_cnt[gi]),
`endif
      .frame_done    (frame_done[gi]),
      .line_err      (line_err[gi])
    );
  end

  typedef struct {
    int unsigned scen;
    int unsigned inst;
    logic [23:0] pix;
    logic        tl;
  } pix_t;

  typedef struct {
    int unsigned scen;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  int          checks = 0;
  int          failures = 0;
  logic [38:0] obs [$];
  int          fd_cnt [4];
  int          stalls [4];
  logic        tog_en = 1'b0;
  pix_t        pv [19];
  word_t       wv [15];
  int unsigned scen_inst [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic        prev_stall [4];
    logic [36:0] prev_beat [4];
    for (int u = 0; u < 4; u++) begin
      prev_stall[u] = 1'b0;
      prev_beat[u]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        if (prev_stall[u]) begin
          check("hold_valid", 64'(m_valid[u]), 64'd1);
          check("hold_beat", 64'({m_data[u], m_keep[u], m_last[u]}), 64'(prev_beat[u]));
        end
        if (m_valid[u] && m_ready[u])
          obs.push_back({2'(u), m_data[u], m_keep[u], m_last[u]});
        if (!rst_n[u] || soft_rst[u]) begin
          stalls[u] = 0;
        end else if (frame_done[u]) begin
          fd_cnt[u]++;
`ifdef UPSP_OUT_PACKER_STALL_CNT_EN
          check("stall_cnt", 64'(stall_cnt[u]), 64'(stalls[u]));
`endif
          stalls[u] = 0;
        end else if (m_valid[u] && !m_ready[u]) begin
          stalls[u]++;
        end
        prev_stall[u] = m_valid[u] && !m_ready[u];
        prev_beat[u]  = {m_data[u], m_keep[u], m_last[u]};
      end
    end
  endtask

  task automatic toggler();
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) m_ready[3] = ~m_ready[3];
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send(input int unsigned u, input logic [23:0] d, input logic l);
    int n = 0;
    s_valid[u] = 1'b1;
    s_data[u]  = d;
    s_last[u]  = l;
    @(negedge clk);
    while (!s_ready[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
  endtask

  task automatic run_scen(input int unsigned s);
    int unsigned u;
    int          fd0;
    int          n;
    u   = scen_inst[s];
    fd0 = fd_cnt[u];
    obs.delete();
    for (int i = 0; i < 19; i++)
      if (pv[i].scen == s) send(pv[i].inst, pv[i].pix, pv[i].tl);
    if (s == 1) begin
      @(negedge clk);
      check("flush_tready", 64'(s_ready[1]), 64'd0);
      @(posedge clk);
      #1;
    end
    repeat (12) @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (wv[i].scen == s) begin
        if (n < obs.size())
          check($sformatf("s%0d_word%0d", s, n), 64'(obs[n]), 64'({2'(u), wv[i].d, wv[i].k, wv[i].l}));
        else
          check($sformatf("s%0d_word%0d_missing", s, n), 64'd0, 64'd1);
        n++;
      end
    end
    check($sformatf("s%0d_word_count", s), 64'(obs.size()), 64'(n));
    check($sformatf("s%0d_frame_done", s), 64'(fd_cnt[u] - fd0), 64'd1);
    check($sformatf("s%0d_line_err", s), 64'(line_err[u]), (s == 4) ? 64'd1 : 64'd0);
  endtask

  initial begin
    for (int u = 0; u < 4; u++) begin
      rst_n[u] = 1'b0; soft_rst[u] = 1'b0; s_valid[u] = 1'b0;
      s_data[u] = '0; s_last[u] = 1'b0; m_ready[u] = 1'b1;
      fd_cnt[u] = 0; stalls[u] = 0;
    end
    scen_inst = '{0, 1, 2, 3, 0};

    pv[0]  = '{0, 0, 24'h030201, 1'b0};
    pv[1]  = '{0, 0, 24'h060504, 1'b0};
    pv[2]  = '{0, 0, 24'h090807, 1'b0};
    pv[3]  = '{0, 0, 24'h0C0B0A, 1'b1};
    pv[4]  = '{1, 1, 24'h030201, 1'b0};
    pv[5]  = '{1, 1, 24'h060504, 1'b1};
    pv[6]  = '{2, 2, 24'hAABBCC, 1'b1};
    pv[7]  = '{3, 3, 24'h030201, 1'b0};
    pv[8]  = '{3, 3, 24'h060504, 1'b0};
    pv[9]  = '{3, 3, 24'h090807, 1'b0};
    pv[10] = '{3, 3, 24'h0C0B0A, 1'b1};
    pv[11] = '{3, 3, 24'h0F0E0D, 1'b0};
    pv[12] = '{3, 3, 24'h121110, 1'b0};
    pv[13] = '{3, 3, 24'h151413, 1'b0};
    pv[14] = '{3, 3, 24'h181716, 1'b1};
    pv[15] = '{4, 0, 24'h030201, 1'b0};
    pv[16] = '{4, 0, 24'h060504, 1'b1};
    pv[17] = '{4, 0, 24'h090807, 1'b0};
    pv[18] = '{4, 0, 24'h0C0B0A, 1'b0};

    wv[0]  = '{0, 32'h04030201, 4'hF, 1'b0};
    wv[1]  = '{0, 32'h08070605, 4'hF, 1'b0};
    wv[2]  = '{0, 32'h0C0B0A09, 4'hF, 1'b1};
    wv[3]  = '{1, 32'h04030201, 4'hF, 1'b0};
    wv[4]  = '{1, 32'h00000605, 4'h3, 1'b1};
    wv[5]  = '{2, 32'h00AABBCC, 4'h7, 1'b1};
    wv[6]  = '{3, 32'h04030201, 4'hF, 1'b0};
    wv[7]  = '{3, 32'h08070605, 4'hF, 1'b0};
    wv[8]  = '{3, 32'h0C0B0A09, 4'hF, 1'b0};
    wv[9]  = '{3, 32'h100F0E0D, 4'hF, 1'b0};
    wv[10] = '{3, 32'h14131211, 4'hF, 1'b0};
    wv[11] = '{3, 32'h18171615, 4'hF, 1'b1};
    wv[12] = '{4, 32'h04030201, 4'hF, 1'b0};
    wv[13] = '{4, 32'h08070605, 4'hF, 1'b0};
    wv[14] = '{4, 32'h0C0B0A09, 4'hF, 1'b1};

    fork
      monitor();
      toggler();
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rst_valid%0d", u), 64'(m_valid[u]), 64'd0);
      check($sformatf("rst_last%0d", u), 64'(m_last[u]), 64'd0);
      check($sformatf("rst_data%0d", u), 64'({m_data[u], m_keep[u]}), 64'd0);
      check($sformatf("rst_fdone%0d", u), 64'(frame_done[u]), 64'd0);
      check($sformatf("rst_lerr%0d", u), 64'(line_err[u]), 64'd0);
      rst_n[u] = 1'b1;
    end
    @(posedge clk);
    #1;

    run_scen(0);
    run_scen(1);
    run_scen(2);
    m_ready[3] = 1'b0;
    tog_en = 1'b1;
    run_scen(3);
    tog_en = 1'b0;
    #2;
    m_ready[3] = 1'b1;
    @(posedge clk);
    #1;
    run_scen(4);

    // line_err stays set until a soft reset
    repeat (5) @(posedge clk);
    #1;
    check("line_err_sticky", 64'(line_err[0]), 64'd1);
    soft_rst[0] = 1'b1;
    @(posedge clk);
    #1;
    soft_rst[0] = 1'b0;
    check("line_err_soft_clear", 64'(line_err[0]), 64'd0);

    // Abort a frame after three pixels; the leftover byte must not leak into the next frame
    for (int i = 0; i < 3; i++) send(0, pv[i].pix, pv[i].tl);
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    check("midrst_valid", 64'(m_valid[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk);
    #1;
    run_scen(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
